interfaz_rx_frame: RTL and testbench

//  Parametrised successor of the RX-side operand interface; sits between rx and ALU.

---
 rtl/interfaz_pkg.sv | 19 +
 rtl/interfaz_rx_frame_if.sv | 27 ++
 rtl/interfaz_rx_frame_watchdog_cnt.sv | 29 ++
 rtl/interfaz_rx_frame.sv | 161 ++++++++++++++++
 tb/tb_interfaz_rx_frame.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/interfaz_pkg.sv
// Shared definitions for the RX frame interface: FSM state encoding and error cause codes.
package interfaz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_GET_CHK = 3'd3,
    ST_VALID   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_OVERRUN  = 2'b10,
    ERR_CHECKSUM = 2'b11
  } err_t;

endpackage

// File: rtl/interfaz_rx_frame_if.sv
// Byte-stream input and ALU-facing frame outputs of interfaz_rx_frame, bundled as one interface.
interface interfaz_rx_frame_if #(
  parameter int NB_DATA     = 8,
  parameter int NB_OPERADOR = 6
);
  logic [NB_DATA-1:0]     i_data;
  logic                   i_done_data;
  logic                   i_alu_ready;
  logic [NB_DATA-1:0]     o_a;
  logic [NB_DATA-1:0]     o_b;
  logic [NB_OPERADOR-1:0] o_op;
  logic                   o_rx_alu_done;
  logic                   o_err;
  logic [1:0]             o_err_code;
  logic                   o_busy;

  // master: the rx/ALU environment; slave: the frame assembler
  modport master (
    output i_data, i_done_data, i_alu_ready,
    input  o_a, o_b, o_op, o_rx_alu_done, o_err, o_err_code, o_busy
  );

  modport slave (
    input  i_data, i_done_data, i_alu_ready,
    output o_a, o_b, o_op, o_rx_alu_done, o_err, o_err_code, o_busy
  );
endinterface

// File: rtl/interfaz_rx_frame_watchdog_cnt.sv
// Inter-byte watchdog: counts while running, one-cycle o_expired when the count reaches MAX-1.
module watchdog_cnt #(
  parameter int MAX = 4096,
  parameter int NB  = $clog2(MAX)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);
  localparam logic [NB-1:0] LAST = NB'(MAX - 1);

  logic [NB-1:0] cnt_reg;

  // Wrapping after LAST keeps o_expired a single-cycle pulse even if i_run stays high.
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clear || !i_run) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // A clear (accepted byte) in the expiry cycle suppresses the pulse.
  assign o_expired = i_run && !i_clear && (cnt_reg == LAST);
endmodule

// File: rtl/interfaz_rx_frame.sv
// Assembles A, B, OP (and CHK when FRAME_CHECKSUM_EN is defined) from the rx byte stream and
// presents the frame to the ALU with valid/ready, plus timeout/overrun/checksum error reporting.
module interfaz_rx_frame
  import interfaz_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_OPERADOR = 6,
  parameter int TIMEOUT_CLK = 4096
) (
  input logic              i_clk,
  input logic              i_rst,
  interfaz_rx_frame_if.slave bus
);
  state_t                 state_reg, state_next;
  logic [NB_DATA-1:0]     sh_a_reg, sh_a_next;
  logic [NB_DATA-1:0]     sh_b_reg, sh_b_next;
`ifdef FRAME_CHECKSUM_EN
  logic [NB_DATA-1:0]     sh_op_reg, sh_op_next;
`endif
  logic [NB_DATA-1:0]     a_reg, a_next;
  logic [NB_DATA-1:0]     b_reg, b_next;
  logic [NB_OPERADOR-1:0] op_reg, op_next;
  logic                   err_reg, err_next;
  err_t                   code_reg, code_next;
  logic                   wd_run;
  logic                   wd_expired;

  assign wd_run = (state_reg == ST_GET_B) || (state_reg == ST_GET_OP) ||
                  (state_reg == ST_GET_CHK);

  watchdog_cnt #(
    .MAX (TIMEOUT_CLK)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (bus.i_done_data),
    .i_run     (wd_run),
    .o_expired (wd_expired)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_reg <= ST_IDLE;
      sh_a_reg  <= '0;
      sh_b_reg  <= '0;
`ifdef FRAME_CHECKSUM_EN
      sh_op_reg <= '0;
`endif
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      err_reg   <= 1'b0;
      code_reg  <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      sh_a_reg  <= sh_a_next;
      sh_b_reg  <= sh_b_next;
`ifdef FRAME_CHECKSUM_EN
      sh_op_reg <= sh_op_next;
`endif
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      err_reg   <= err_next;
      code_reg  <= code_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sh_a_next  = sh_a_reg;
    sh_b_next  = sh_b_reg;
`ifdef FRAME_CHECKSUM_EN
    sh_op_next = sh_op_reg;
`endif
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    err_next   = 1'b0;
    code_next  = code_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.i_done_data) begin
          sh_a_next  = bus.i_data;
          state_next = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (bus.i_done_data) begin
          sh_b_next  = bus.i_data;
          state_next = ST_GET_OP;
        end else if (wd_expired) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
          code_next  = ERR_TIMEOUT;
        end
      end
      ST_GET_OP: begin
        if (bus.i_done_data) begin
`ifdef FRAME_CHECKSUM_EN
          sh_op_next = bus.i_data;
          state_next = ST_GET_CHK;
`else
          a_next     = sh_a_reg;
          b_next     = sh_b_reg;
          op_next    = bus.i_data[NB_OPERADOR-1:0];
          state_next = ST_VALID;
`endif
        end else if (wd_expired) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
          code_next  = ERR_TIMEOUT;
        end
      end
`ifdef FRAME_CHECKSUM_EN
      ST_GET_CHK: begin
        if (bus.i_done_data) begin
          if (bus.i_data == (sh_a_reg ^ sh_b_reg ^ sh_op_reg)) begin
            a_next     = sh_a_reg;
            b_next     = sh_b_reg;
            op_next    = sh_op_reg[NB_OPERADOR-1:0];
            state_next = ST_VALID;
          end else begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
            code_next  = ERR_CHECKSUM;
          end
        end else if (wd_expired) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
          code_next  = ERR_TIMEOUT;
        end
      end
`endif
      ST_VALID: begin
        // A byte arriving together with ready starts the next frame instead of being lost.
        if (bus.i_alu_ready) begin
          if (bus.i_done_data) begin
            sh_a_next  = bus.i_data;
            state_next = ST_GET_B;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (bus.i_done_data) begin
          err_next  = 1'b1;
          code_next = ERR_OVERRUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.o_a           = a_reg;
  assign bus.o_b           = b_reg;
  assign bus.o_op          = op_reg;
  assign bus.o_rx_alu_done = (state_reg == ST_VALID);
  assign bus.o_err         = err_reg;
  assign bus.o_err_code    = code_reg;
  assign bus.o_busy        = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_interfaz_rx_frame.sv
// Self-checking bench for interfaz_rx_frame: directed scenarios then randomized byte traffic,
// compared each cycle against a frame-level reference model.
module tb_interfaz_rx_frame;
  localparam int T = 64;
`ifdef FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  interfaz_rx_frame_if #(.NB_DATA(8), .NB_OPERADOR(6)) bus ();

  interfaz_rx_frame #(
    .NB_DATA     (8),
    .NB_OPERADOR (6),
    .TIMEOUT_CLK (T)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the frame being collected, silence length, presented frame.
  logic [7:0] frame_q[$];
  int         age;
  bit         m_valid;
  logic [7:0] m_a, m_b;
  logic [5:0] m_op;
  bit         m_err;
  logic [1:0] m_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic complete_frame();
    bit ok;
    ok = 1'b1;
    if (FRAME_LEN == 4) ok = (frame_q[3] == (frame_q[0] ^ frame_q[1] ^ frame_q[2]));
    if (ok) begin
      m_a     = frame_q[0];
      m_b     = frame_q[1];
      m_op    = frame_q[2][5:0];
      m_valid = 1'b1;
    end else begin
      m_err  = 1'b1;
      m_code = 2'b11;
    end
    frame_q.delete();
  endtask

  // One clock cycle: drive inputs, advance the model, compare every output after the edge.
  task automatic step(input bit strobe, input logic [7:0] d, input bit rdy);
    bus.i_done_data = strobe;
    bus.i_data      = d;
    bus.i_alu_ready = rdy;
    m_err = 1'b0;
    if (m_valid) begin
      if (rdy) begin
        m_valid = 1'b0;
        if (strobe) begin
          frame_q.delete();
          frame_q.push_back(d);
          age = 0;
        end
      end else if (strobe) begin
        m_err  = 1'b1;
        m_code = 2'b10;
      end
    end else if (strobe) begin
      frame_q.push_back(d);
      age = 0;
      if (frame_q.size() == FRAME_LEN) complete_frame();
    end else if (frame_q.size() > 0) begin
      age++;
      if (age == T) begin
        frame_q.delete();
        m_err  = 1'b1;
        m_code = 2'b01;
      end
    end
    @(posedge clk);
    #1;
    bus.i_done_data = 1'b0;
    chk("valid", bus.o_rx_alu_done, m_valid);
    chk("busy",  bus.o_busy, m_valid || (frame_q.size() > 0));
    chk("err",   bus.o_err, m_err);
    chk("code",  bus.o_err_code, m_code);
    chk("a",     bus.o_a, m_a);
    chk("b",     bus.o_b, m_b);
    chk("op",    bus.o_op, m_op);
  endtask

  task automatic send(input logic [7:0] d, input int gap, input bit rdy);
    repeat (gap) step(1'b0, 8'h00, rdy);
    step(1'b1, d, rdy);
    $display("txn byte=%h gap=%0d rdy=%0b valid=%0b err=%0b code=%0b a=%h b=%h op=%h",
             d, gap, rdy, bus.o_rx_alu_done, bus.o_err, bus.o_err_code, bus.o_a, bus.o_b, bus.o_op);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, 8'h00, rdy);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input int gap, input bit rdy);
    send(a, gap, rdy);
    send(b, gap, rdy);
    send(op, gap, rdy);
    if (FRAME_LEN == 4) send(a ^ b ^ op, gap, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.i_done_data = 1'b0;
    bus.i_alu_ready = 1'b0;
    bus.i_data      = 8'h00;
    @(posedge clk);
    #1;
    frame_q.delete();
    age = 0; m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_err = 0; m_code = 0;
    chk("rst_valid", bus.o_rx_alu_done, 0);
    chk("rst_busy",  bus.o_busy, 0);
    chk("rst_err",   bus.o_err, 0);
    chk("rst_code",  bus.o_err_code, 0);
    chk("rst_a",     bus.o_a, 0);
    chk("rst_b",     bus.o_b, 0);
    chk("rst_op",    bus.o_op, 0);
    $display("txn reset");
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    int         gap;
    bit         rdy;

    bus.i_data = 8'h00;
    bus.i_done_data = 1'b0;
    bus.i_alu_ready = 1'b0;
    do_reset();

    // 1: basic frame with ready held high
    send_frame(8'h06, 8'h01, 8'h20, 16, 1'b1);
    chk("t1_valid", bus.o_rx_alu_done, 1);
    chk("t1_a", bus.o_a, 8'h06);
    chk("t1_b", bus.o_b, 8'h01);
    chk("t1_op", bus.o_op, 6'h20);
    idle(1, 1'b1);
    chk("t1_valid_drop", bus.o_rx_alu_done, 0);
    idle(2, 1'b1);

    // 2: lone byte then silence -> timeout
    send(8'h07, 3, 1'b1);
    idle(T + 2, 1'b1);
    chk("t2_code", bus.o_err_code, 2'b01);
    chk("t2_busy", bus.o_busy, 0);
    chk("t2_a", bus.o_a, 8'h06);

    // 3: overrun while frame held
    send_frame(8'h31, 8'h32, 8'h33, 2, 1'b0);
    idle(3, 1'b0);
    send(8'h55, 2, 1'b0);
    chk("t3_err", bus.o_err, 1);
    chk("t3_code", bus.o_err_code, 2'b10);
    chk("t3_valid", bus.o_rx_alu_done, 1);
    chk("t3_a", bus.o_a, 8'h31);
    idle(1, 1'b1);
    chk("t3_valid_drop", bus.o_rx_alu_done, 0);

    // 4: strobe and ready in the same VALID cycle
    send_frame(8'h41, 8'h42, 8'h43, 1, 1'b0);
    idle(2, 1'b0);
    send(8'h0A, 0, 1'b1);
    chk("t4_busy", bus.o_busy, 1);
    chk("t4_valid", bus.o_rx_alu_done, 0);
    send(8'h02, 3, 1'b1);
    send(8'h21, 3, 1'b1);
    if (FRAME_LEN == 4) send(8'h0A ^ 8'h02 ^ 8'h21, 3, 1'b1);
    chk("t4_a", bus.o_a, 8'h0A);
    chk("t4_b", bus.o_b, 8'h02);
    idle(2, 1'b1);

`ifdef FRAME_CHECKSUM_EN
    // 5: checksum good then bad
    send(8'h03, 1, 1'b1); send(8'h04, 1, 1'b1); send(8'h20, 1, 1'b1); send(8'h27, 1, 1'b1);
    chk("t5_valid", bus.o_rx_alu_done, 1);
    idle(2, 1'b1);
    send(8'h03, 1, 1'b1); send(8'h04, 1, 1'b1); send(8'h20, 1, 1'b1); send(8'h26, 1, 1'b1);
    chk("t5_err", bus.o_err, 1);
    chk("t5_code", bus.o_err_code, 2'b11);
    chk("t5_novalid", bus.o_rx_alu_done, 0);
    idle(2, 1'b1);
`endif

    // 6: reset mid-frame, then a clean frame
    send(8'h99, 1, 1'b1);
    send(8'h98, 1, 1'b1);
    do_reset();
    send(8'h11, 1, 1'b1);
    chk("t6_noerr", bus.o_err, 0);
    send(8'h22, 1, 1'b1);
    send(8'h08, 1, 1'b1);
    if (FRAME_LEN == 4) send(8'h11 ^ 8'h22 ^ 8'h08, 1, 1'b1);
    chk("t6_a", bus.o_a, 8'h11);
    chk("t6_code", bus.o_err_code, 0);
    idle(2, 1'b1);

    // Randomized traffic, including silences right at the timeout boundary
    for (int i = 0; i < 300; i++) begin
      d   = 8'($urandom);
      gap = ($urandom_range(0, 7) == 0) ? (T - 1 + $urandom_range(0, 2)) : $urandom_range(0, 5);
      rdy = ($urandom_range(0, 3) != 0);
      if (FRAME_LEN == 4 && !m_valid && frame_q.size() == 3 && $urandom_range(0, 1) == 1)
        d = frame_q[0] ^ frame_q[1] ^ frame_q[2];
      if ($urandom_range(0, 39) == 0) do_reset();
      send(d, gap, rdy);
    end
    idle(T + 2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
